adc_ch_scheduler: RTL and testbench
===================================

ADC_CH_SCHEDULER -- requirements
Module: adc_ch_scheduler

Interface
REQ-001 Parameter DataWidth, default 10, width of ADC conversion result.
REQ-002 Parameter Gap, default 4, idle clock cycles between consecutive conversions (0 allowed).
REQ-003 Parameter Timeout, default 1023, max cycles waited for done_i before abandoning a conversion (>=1).
REQ-004 clk_i  input  1  single clock, all logic rising-edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 en_i  input  1  level; 1 = run continuous round-robin scan.
REQ-007 ch_mask_i  input  4  bit N = 1 enables channel N in scan.
REQ-008 done_i  input  1  one-cycle pulse from SPI master, conversion complete.
REQ-009 data_i  input  DataWidth  conversion result, valid while done_i = 1.
REQ-010 sel_o  output  2  channel select driving the 4:1 command mux.
REQ-011 start_o  output  1  one-cycle pulse starting an SPI transaction.
REQ-012 ch0_data_o..ch3_data_o  output  DataWidth each  last result per channel.
REQ-013 valid_o  output  4  bit N pulses one cycle when chN_data_o updates.
REQ-014 scan_done_o  output  1  one-cycle pulse at end of each full scan round.
REQ-015 busy_o  output  1  1 whenever state is not IDLE.
REQ-016 err_o  output  1  sticky timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, SELECT, START, WAIT, GAP; all outputs registered.
REQ-018 IDLE -> SELECT when en_i = 1 and ch_mask_i != 0; current channel = lowest set mask bit on first entry.
REQ-019 en_i = 1 with ch_mask_i = 0 SHALL hold IDLE, no start_o.
REQ-020 sel_o SHALL change only on entry to SELECT; SELECT lasts exactly 1 cycle (mux settle).
REQ-021 START lasts 1 cycle with start_o = 1; start_o = 0 in all other states.
REQ-022 WAIT samples done_i only in WAIT; done_i in any other state SHALL be ignored.
REQ-023 done_i = 1 in WAIT: capture data_i into chN_data_o (N = sel_o) and pulse valid_o[N], both visible the following cycle; go to GAP.
REQ-024 WAIT cycle counter reaching Timeout without done_i: set err_o, no data update, no valid pulse, go to GAP.
REQ-025 GAP SHALL last Gap cycles; Gap = 0 SHALL bypass GAP (direct to next-channel decision).
REQ-026 Next channel = next set bit of ch_mask_i above current, wrapping 3 -> 0; mask sampled at decision time.
REQ-027 scan_done_o SHALL pulse when the decision wraps (next channel <= current), including single-channel mask.
REQ-028 At decision: en_i = 0 or ch_mask_i = 0 -> IDLE; otherwise SELECT with new channel.
REQ-029 en_i deassertion mid-conversion SHALL NOT abort; current conversion completes (or times out) and its result is stored.
REQ-030 Mask change mid-conversion SHALL NOT affect the active channel.
REQ-031 Throughput: one conversion per (2 + SPI latency + 1 + Gap) cycles.
REQ-032 valid_o bits and scan_done_o SHALL never be high more than one consecutive cycle.

Reset
REQ-033 rst_i = 1 on a clock edge SHALL force IDLE from any state, including WAIT.
REQ-034 Reset values: sel_o = 0, start_o = 0, chN_data_o = 0, valid_o = 0, scan_done_o = 0, busy_o = 0, err_o = 0, counters = 0.
REQ-035 done_i arriving after reset for a pre-reset transaction SHALL be ignored (state IDLE).
REQ-036 err_o SHALL clear only by rst_i.

Verification
REQ-037 Mask 4'b1111, en_i = 1, SPI model done_i 20 cycles after start_o, data = 10*ch+1 -> sel_o sequence 0,1,2,3,0; ch0..3_data_o = 1,11,21,31; scan_done_o pulses once after ch3.
REQ-038 Mask 4'b1010 -> sel_o alternates 1,3,1,3; channels 0 and 2 never start; scan_done_o after each ch3 result.
REQ-039 Mask 4'b0100 -> repeated ch2 conversions, scan_done_o pulses after every conversion; Gap = 4 cycles between done_i and next start_o's SELECT.
REQ-040 SPI model never asserts done_i on ch1 -> after Timeout = 1023 WAIT cycles err_o = 1, ch1_data_o unchanged, valid_o[1] never pulses, scan continues to ch2.
REQ-041 en_i dropped 3 cycles after start_o -> result stored, valid_o pulses, then IDLE with busy_o = 0; no further start_o.
REQ-042 rst_i pulsed during WAIT, then stray done_i with data 0x3FF -> all outputs at reset values, data registers stay 0.

Source files
------------

// File: rtl/adc_ch_scheduler.sv
// Round-robin scan scheduler for a 4-channel SPI ADC: selects a channel, fires a
// conversion, waits for its result (with timeout), idles Gap cycles, moves on.
module adc_ch_scheduler #(
    parameter int DataWidth = 10,
    parameter int Gap       = 4,
    parameter int Timeout   = 1023
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [3:0]           ch_mask_i,
    input  logic                 done_i,
    input  logic [DataWidth-1:0] data_i,
    output logic [1:0]           sel_o,
    output logic                 start_o,
    output logic [DataWidth-1:0] ch0_data_o,
    output logic [DataWidth-1:0] ch1_data_o,
    output logic [DataWidth-1:0] ch2_data_o,
    output logic [DataWidth-1:0] ch3_data_o,
    output logic [3:0]           valid_o,
    output logic                 scan_done_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int CntMax = (Timeout > Gap) ? Timeout : Gap;
    localparam int CntW   = (CntMax < 1) ? 1 : $clog2(CntMax + 1);

    typedef enum logic [2:0] {IDLE, SELECT, START, WAIT, GAP} state_t;

    state_t               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [DataWidth-1:0] data_q [4];
    logic [DataWidth-1:0] data_d [4];
    logic [1:0]           sel_d, first_ch, next_ch, idx;
    logic                 next_wrap, start_d, scan_d, busy_d, err_d, decide, leave_wait;
    logic [3:0]           valid_d;

    // Lowest enabled channel, and next enabled channel after sel_o (offset 4 = itself).
    always_comb begin
        first_ch  = '0;
        next_ch   = sel_o;
        next_wrap = 1'b1;
        idx       = '0;
        for (int unsigned b = 4; b > 0; b--) begin
            if (ch_mask_i[b-1]) first_ch = 2'(b - 1);
        end
        for (int unsigned off = 4; off > 0; off--) begin
            idx = sel_o + 2'(off);
            if (ch_mask_i[idx]) begin
                next_ch   = idx;
                next_wrap = (idx <= sel_o);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_o;
        start_d    = 1'b0;
        valid_d    = '0;
        scan_d     = 1'b0;
        err_d      = err_o;
        data_d     = data_q;
        decide     = 1'b0;
        leave_wait = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i && ch_mask_i != '0) begin
                    state_d = SELECT;
                    sel_d   = first_ch;
                end
            end
            SELECT: begin
                state_d = START;
                start_d = 1'b1;
            end
            START: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (done_i) begin
                    data_d[sel_o]  = data_i;
                    valid_d[sel_o] = 1'b1;
                    leave_wait     = 1'b1;
                end else if (cnt_q == CntW'(Timeout - 1)) begin
                    err_d      = 1'b1;
                    leave_wait = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CntW'(Gap - 1)) decide = 1'b1;
                else                         cnt_d  = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (leave_wait) begin
            cnt_d = '0;
            if (Gap == 0) decide  = 1'b1;
            else          state_d = GAP;
        end

        // Mask and enable are sampled only here, so mid-conversion changes never disturb sel_o.
        if (decide) begin
            if (ch_mask_i != '0 && next_wrap) scan_d = 1'b1;
            if (en_i && ch_mask_i != '0) begin
                state_d = SELECT;
                sel_d   = next_ch;
            end else begin
                state_d = IDLE;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_o       <= '0;
            start_o     <= 1'b0;
            valid_o     <= '0;
            scan_done_o <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) data_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_o       <= sel_d;
            start_o     <= start_d;
            valid_o     <= valid_d;
            scan_done_o <= scan_d;
            busy_o      <= busy_d;
            err_o       <= err_d;
            for (int unsigned i = 0; i < 4; i++) data_q[i] <= data_d[i];
        end
    end

    assign ch0_data_o = data_q[0];
    assign ch1_data_o = data_q[1];
    assign ch2_data_o = data_q[2];
    assign ch3_data_o = data_q[3];

endmodule

// File: tb/tb_adc_ch_scheduler.sv
// Directed bench for adc_ch_scheduler: SPI responder model feeds a result scoreboard,
// a monitor logs starts/results/pulses, and one initial block runs and checks each scenario.
module tb_adc_ch_scheduler;

    localparam int DW    = 10;
    localparam int GAP_C = 4;
    localparam int TMO   = 1023;
    localparam int LAT   = 20;

    logic          clk = 1'b0;
    logic          rst_i, en_i, done_i;
    logic [3:0]    ch_mask_i;
    logic [DW-1:0] data_i;
    logic [1:0]    sel_o;
    logic          start_o, scan_done_o, busy_o, err_o;
    logic [DW-1:0] ch0_data_o, ch1_data_o, ch2_data_o, ch3_data_o;
    logic [3:0]    valid_o;

    logic          spi_done = 1'b0, stray_done = 1'b0;
    logic [DW-1:0] spi_data = '0, stray_data = '0;
    int            drop_ch = -1;

    assign done_i = spi_done | stray_done;
    assign data_i = stray_done ? stray_data : spi_data;

    always #5 clk = ~clk;

    adc_ch_scheduler #(.DataWidth(DW), .Gap(GAP_C), .Timeout(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .ch_mask_i(ch_mask_i),
        .done_i(done_i), .data_i(data_i), .sel_o(sel_o), .start_o(start_o),
        .ch0_data_o(ch0_data_o), .ch1_data_o(ch1_data_o),
        .ch2_data_o(ch2_data_o), .ch3_data_o(ch3_data_o),
        .valid_o(valid_o), .scan_done_o(scan_done_o), .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct { int ch; int data; } res_t;
    res_t exp_q[$];
    res_t obs_q[$];
    int   start_log[$];
    int   start_cyc[$];
    int   cyc = 0, scan_cnt = 0, dbl_cnt = 0, multi_cnt = 0, err_rise = -1;
    int   n_cmp = 0, n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ch_data(int i);
        case (i)
            0: return int'(ch0_data_o);
            1: return int'(ch1_data_o);
            2: return int'(ch2_data_o);
            default: return int'(ch3_data_o);
        endcase
    endfunction

    // SPI responder: done_i LAT cycles after start_o, data = 10*ch+1; reset cancels it.
    initial begin
        int   ch;
        logic killed;
        forever begin
            @(negedge clk);
            if (start_o === 1'b1 && !rst_i) begin
                ch     = int'(sel_o);
                killed = 1'b0;
                for (int i = 0; i < LAT; i++) begin
                    @(negedge clk);
                    if (rst_i) killed = 1'b1;
                end
                if (!killed && ch != drop_ch) begin
                    spi_data = DW'(10 * ch + 1);
                    spi_done = 1'b1;
                    exp_q.push_back('{ch, 10 * ch + 1});
                    @(negedge clk);
                    spi_done = 1'b0;
                end
            end
        end
    end

    // Monitor: logs observed events just after each rising edge.
    initial begin
        logic [3:0] pv;
        logic       ps, pe;
        pv = '0; ps = 1'b0; pe = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (start_o) begin
                start_log.push_back(int'(sel_o));
                start_cyc.push_back(cyc);
            end
            if (valid_o != '0) begin
                if ($countones(valid_o) != 1) multi_cnt++;
                for (int i = 0; i < 4; i++)
                    if (valid_o[i]) obs_q.push_back('{i, ch_data(i)});
            end
            if ((valid_o & pv) != '0) dbl_cnt++;
            if (scan_done_o && ps) dbl_cnt++;
            if (scan_done_o) scan_cnt++;
            if (err_o && !pe) err_rise = cyc;
            pv = valid_o; ps = scan_done_o; pe = err_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sel"}, 32'(sel_o), 0);
        check({tag, "_start"}, 32'(start_o), 0);
        check({tag, "_valid"}, 32'(valid_o), 0);
        check({tag, "_scan"}, 32'(scan_done_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_err"}, 32'(err_o), 0);
        check({tag, "_ch0"}, 32'(ch0_data_o), 0);
        check({tag, "_ch1"}, 32'(ch1_data_o), 0);
        check({tag, "_ch2"}, 32'(ch2_data_o), 0);
        check({tag, "_ch3"}, 32'(ch3_data_o), 0);
    endtask

    task automatic check_sb(input string tag, input int n);
        res_t e, o;
        check({tag, "_sb_exp_count"}, 32'(exp_q.size()), 32'(n));
        check({tag, "_sb_obs_count"}, 32'(obs_q.size()), 32'(n));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_sb_ch"}, 32'(o.ch), 32'(e.ch));
            check({tag, "_sb_data"}, 32'(o.data), 32'(e.data));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic check_seq(input string tag, input int seq[$]);
        check({tag, "_nstarts"}, 32'(start_log.size()), 32'(seq.size()));
        for (int i = 0; i < seq.size() && i < start_log.size(); i++)
            check({tag, "_sel_seq"}, 32'(start_log[i]), 32'(seq[i]));
    endtask

    task automatic wait_starts(input string tag, input int n, input int bound);
        int k = 0;
        while (start_log.size() < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_wait_starts"}, 32'(start_log.size() >= n), 1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int k = 0;
        while (busy_o !== 1'b0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle_busy"}, 32'(busy_o), 0);
    endtask

    task automatic clear_logs();
        start_log.delete();
        start_cyc.delete();
        exp_q.delete();
        obs_q.delete();
        scan_cnt = 0;
    endtask

    initial begin
        rst_i = 1'b1; en_i = 1'b0; ch_mask_i = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_i = 1'b0;

        // Enabled with empty mask: must stay idle.
        en_i = 1'b1;
        repeat (10) @(negedge clk);
        check("mask0_busy", 32'(busy_o), 0);
        check("mask0_starts", 32'(start_log.size()), 0);

        // Full mask scan; enable dropped 3 cycles after the fifth start.
        clear_logs();
        ch_mask_i = 4'b1111;
        wait_starts("full", 5, 400);
        repeat (3) @(negedge clk);
        en_i = 1'b0;
        wait_idle("full", 100);
        repeat (30) @(negedge clk);
        check_seq("full", '{0, 1, 2, 3, 0});
        if (start_cyc.size() >= 2)
            check("full_period", 32'(start_cyc[1] - start_cyc[0]), 32'(LAT + GAP_C + 2));
        check_sb("full", 5);
        check("full_ch0", 32'(ch0_data_o), 1);
        check("full_ch1", 32'(ch1_data_o), 11);
        check("full_ch2", 32'(ch2_data_o), 21);
        check("full_ch3", 32'(ch3_data_o), 31);
        check("full_scan_cnt", 32'(scan_cnt), 1);
        check("full_err", 32'(err_o), 0);

        // Sparse mask 1010.
        clear_logs();
        ch_mask_i = 4'b1010;
        en_i = 1'b1;
        wait_starts("odd", 4, 400);
        en_i = 1'b0;
        wait_idle("odd", 100);
        repeat (10) @(negedge clk);
        check_seq("odd", '{1, 3, 1, 3});
        check_sb("odd", 4);
        check("odd_scan_cnt", 32'(scan_cnt), 2);

        // Single channel: every conversion wraps.
        clear_logs();
        ch_mask_i = 4'b0100;
        en_i = 1'b1;
        wait_starts("single", 3, 400);
        en_i = 1'b0;
        wait_idle("single", 100);
        repeat (10) @(negedge clk);
        check_seq("single", '{2, 2, 2});
        if (start_cyc.size() >= 3) begin
            check("single_period1", 32'(start_cyc[1] - start_cyc[0]), 32'(LAT + GAP_C + 2));
            check("single_period2", 32'(start_cyc[2] - start_cyc[1]), 32'(LAT + GAP_C + 2));
        end
        check_sb("single", 3);
        check("single_scan_cnt", 32'(scan_cnt), 3);

        // Channel 1 never answers: timeout, sticky error, scan moves on.
        clear_logs();
        drop_ch = 1;
        ch_mask_i = 4'b1111;
        en_i = 1'b1;
        wait_starts("tmo", 3, 3000);
        en_i = 1'b0;
        wait_idle("tmo", 100);
        repeat (10) @(negedge clk);
        check_seq("tmo", '{0, 1, 2});
        check("tmo_err", 32'(err_o), 1);
        if (start_cyc.size() >= 2)
            check("tmo_err_time", 32'(err_rise - start_cyc[1]), 32'(TMO + 1));
        check_sb("tmo", 2);
        check("tmo_ch1_kept", 32'(ch1_data_o), 11);
        check("tmo_ch2", 32'(ch2_data_o), 21);
        repeat (5) @(negedge clk);
        check("tmo_err_sticky", 32'(err_o), 1);

        // Reset during WAIT, then a stray done with all-ones data.
        clear_logs();
        drop_ch = -1;
        en_i = 1'b1;
        wait_starts("rstwait", 1, 50);
        repeat (5) @(negedge clk);
        check("rstwait_busy_before", 32'(busy_o), 1);
        rst_i = 1'b1;
        en_i  = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        stray_data = 10'h3FF;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (30) @(negedge clk);
        check_reset_vals("rstwait");
        check("rstwait_valid_seen", 32'(obs_q.size()), 0);
        check("rstwait_nstarts", 32'(start_log.size()), 1);

        check("pulse_double", 32'(dbl_cnt), 0);
        check("valid_multi", 32'(multi_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
